pixel_loader: RTL and testbench

Parametrised serial-to-parallel image loader for the BNN input path. Accepts an image of `N_PIX` binary pixels as `LANES`-bit beats under a valid/ready handshake while the top-level FSM is in its load state. It presents the whole image in parallel to the first layer, signals completion, and can be cleared and reloaded for back-to-back inferences without a reset.

---
 rtl/pixel_loader_if.sv | 11 +
 rtl/pixel_loader.sv | 131 +++++++++++++
 tb/tb_pixel_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_loader_if.sv
// Valid/ready beat channel feeding pixel_loader; LANES pixels per beat.
interface pixel_loader_if #(
  parameter int LANES = 1
);
  logic             in_valid;
  logic [LANES-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pixel_loader.sv
// Serial-to-parallel binary image loader for the BNN input path.
// Optional feature macro: PIXEL_LOADER_OVERRUN_EN adds a sticky 'overrun' flag.
module pixel_loader #(
  parameter int          N_PIX      = 784,
  parameter int          LANES      = 1,
  parameter logic [2:0]  LOAD_STATE = 3'b001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic             clear,
  pixel_loader_if.slave    bus,
  output logic [N_PIX-1:0] pixels,
  output logic             load_done,
  output logic [7:0]       frames
`ifdef PIXEL_LOADER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int BEATS = N_PIX / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((N_PIX % LANES) != 0) begin : g_lanes_check
      $error("pixel_loader: LANES must divide N_PIX");
    end
  endgenerate

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [N_PIX-1:0] pixels_q, pixels_d;
  logic             load_done_q, load_done_d;
  logic [7:0]       frames_q, frames_d;
  logic [N_PIX-1:0] shifted;
  logic             in_ready;
  logic             accept;
  logic             last_beat;
`ifdef PIXEL_LOADER_OVERRUN_EN
  logic             overrun_q, overrun_d;
`endif

  // New beats enter at the top so the first pixel sent ends up at bit 0.
  generate
    if (LANES == N_PIX) begin : g_shift_whole
      assign shifted = bus.in_data;
    end else begin : g_shift_part
      assign shifted = {bus.in_data, pixels_q[N_PIX-1:LANES]};
    end
  endgenerate

  assign in_ready     = (fsm_q == LOAD) && (state == LOAD_STATE) && !clear;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_valid && in_ready;
  assign last_beat    = (beat_cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    fsm_d       = fsm_q;
    beat_cnt_d  = beat_cnt_q;
    pixels_d    = pixels_q;
    load_done_d = load_done_q;
    frames_d    = frames_q;
`ifdef PIXEL_LOADER_OVERRUN_EN
    overrun_d   = overrun_q;
`endif
    if (clear) begin
      fsm_d       = LOAD;
      beat_cnt_d  = '0;
      pixels_d    = '0;
      load_done_d = 1'b0;
`ifdef PIXEL_LOADER_OVERRUN_EN
      overrun_d   = 1'b0;
`endif
    end else begin
      if (accept) begin
        pixels_d = shifted;
        if (last_beat) begin
          fsm_d       = FULL;
          beat_cnt_d  = '0;
          load_done_d = 1'b1;
          if (frames_q != 8'hFF) begin
            frames_d = frames_q + 8'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
`ifdef PIXEL_LOADER_OVERRUN_EN
      if ((fsm_q == FULL) && (state == LOAD_STATE) && bus.in_valid) begin
        overrun_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= LOAD;
      beat_cnt_q  <= '0;
      pixels_q    <= '0;
      load_done_q <= 1'b0;
      frames_q    <= 8'd0;
`ifdef PIXEL_LOADER_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      beat_cnt_q  <= beat_cnt_d;
      pixels_q    <= pixels_d;
      load_done_q <= load_done_d;
      frames_q    <= frames_d;
`ifdef PIXEL_LOADER_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign pixels    = pixels_q;
  assign load_done = load_done_q;
  assign frames    = frames_q;
`ifdef PIXEL_LOADER_OVERRUN_EN
  assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: 784x1, 784x4 and a tiny 8x4 instance
// for frame-counter saturation.
module tb_pixel_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] st1, st4, sts;
  logic clr1, clr4, clrs;
  logic [783:0] pix1, pix4;
  logic [7:0] pixs;
  logic done1, done4, dones;
  logic [7:0] fr1, fr4, frs;
`ifdef PIXEL_LOADER_OVERRUN_EN
  logic ov1, ov4, ovs;
`endif

  int checks = 0;
  int failures = 0;

  pixel_loader_if #(.LANES(1)) bus1 ();
  pixel_loader_if #(.LANES(4)) bus4 ();
  pixel_loader_if #(.LANES(4)) bus_s ();

  pixel_loader #(.N_PIX(784), .LANES(1), .LOAD_STATE(3'b001)) dut1 (
    .clk(clk), .reset_n(reset_n), .state(st1), .clear(clr1), .bus(bus1.slave),
    .pixels(pix1), .load_done(done1), .frames(fr1)
`ifdef PIXEL_LOADER_OVERRUN_EN
    , .overrun(ov1)
`endif
  );

  pixel_loader #(.N_PIX(784), .LANES(4), .LOAD_STATE(3'b001)) dut4 (
    .clk(clk), .reset_n(reset_n), .state(st4), .clear(clr4), .bus(bus4.slave),
    .pixels(pix4), .load_done(done4), .frames(fr4)
`ifdef PIXEL_LOADER_OVERRUN_EN
    , .overrun(ov4)
`endif
  );

  pixel_loader #(.N_PIX(8), .LANES(4), .LOAD_STATE(3'b001)) dut_s (
    .clk(clk), .reset_n(reset_n), .state(sts), .clear(clrs), .bus(bus_s.slave),
    .pixels(pixs), .load_done(dones), .frames(frs)
`ifdef PIXEL_LOADER_OVERRUN_EN
    , .overrun(ovs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] state;
    logic       clear;
    logic       valid;
    logic [3:0] data;
    logic       exp_ready;
    logic [3:0] exp_top;
    logic [3:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [783:0] act, input logic [783:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic pbit(input int mode, input int k);
    if (mode == 0) return (k % 3) == 0;
    return (k % 5) == 1;
  endfunction

  function automatic logic [783:0] img(input int mode);
    logic [783:0] v;
    for (int k = 0; k < 784; k++) v[k] = pbit(mode, k);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    st4 = v.state;
    clr4 = v.clear;
    bus4.in_valid = v.valid;
    bus4.in_data = v.data;
    #1;
    checkOutput("vec_ready", 784'(bus4.in_ready), 784'(v.exp_ready));
    step();
    checkOutput("vec_top", 784'(pix4[783:780]), 784'(v.exp_top));
    checkOutput("vec_next", 784'(pix4[779:776]), 784'(v.exp_next));
  endtask

  task automatic send1(input int mode, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      st1 = 3'b001;
      bus1.in_valid = 1'b1;
      bus1.in_data = pbit(mode, k);
      step();
    end
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [783:0] exp_a;
    logic [783:0] exp_part;
    logic [783:0] hold;

    vecs[0] = '{3'b000, 1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0};
    vecs[1] = '{3'b001, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0};
    vecs[2] = '{3'b001, 1'b0, 1'b1, 4'h3, 1'b1, 4'h3, 4'h0};
    vecs[3] = '{3'b001, 1'b0, 1'b0, 4'hF, 1'b1, 4'h3, 4'h0};
    vecs[4] = '{3'b010, 1'b0, 1'b1, 4'hF, 1'b0, 4'h3, 4'h0};
    vecs[5] = '{3'b001, 1'b0, 1'b1, 4'h9, 1'b1, 4'h9, 4'h3};
    vecs[6] = '{3'b001, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0, 4'h0};
    vecs[7] = '{3'b001, 1'b0, 1'b1, 4'h6, 1'b1, 4'h6, 4'h0};

    reset_n = 1'b0;
    st1 = 3'b000; st4 = 3'b000; sts = 3'b000;
    clr1 = 1'b0; clr4 = 1'b0; clrs = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0;
    bus4.in_valid = 1'b0; bus4.in_data = '0;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0;
    #1;
    checkOutput("rst_pixels", pix1, '0);
    checkOutput("rst_done", 784'(done1), '0);
    checkOutput("rst_frames", 784'(fr1), '0);
    checkOutput("rst_ready", 784'(bus1.in_ready), '0);
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] table vectors on 784x4");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    checkOutput("vec_done", 784'(done4), '0);

    $display("[TB] full image on 784x4");
    clr4 = 1'b1; bus4.in_valid = 1'b0;
    step();
    clr4 = 1'b0;
    for (int b = 0; b < 196; b++) begin
      st4 = 3'b001;
      bus4.in_valid = 1'b1;
      bus4.in_data = 4'hA;
      step();
      if (b == 194) checkOutput("l4_done_early", 784'(done4), '0);
    end
    exp_a = {196{4'hA}};
    checkOutput("l4_done", 784'(done4), 784'(1));
    checkOutput("l4_pixels", pix4, exp_a);
    checkOutput("l4_frames", 784'(fr4), 784'(1));
    bus4.in_data = 4'h5;
    #1;
    checkOutput("l4_full_ready", 784'(bus4.in_ready), '0);
    step();
    bus4.in_valid = 1'b0;
    checkOutput("l4_full_hold", pix4, exp_a);
    checkOutput("l4_full_done", 784'(done4), 784'(1));

    $display("[TB] continuous image on 784x1");
    send1(0, 0, 782);
    checkOutput("l1_done_early", 784'(done1), '0);
    send1(0, 783, 783);
    checkOutput("l1_done", 784'(done1), 784'(1));
    checkOutput("l1_pixels", pix1, img(0));
    checkOutput("l1_frames", 784'(fr1), 784'(1));
`ifdef PIXEL_LOADER_OVERRUN_EN
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    checkOutput("ovr_set", 784'(ov1), 784'(1));
    step();
    checkOutput("ovr_sticky", 784'(ov1), 784'(1));
`endif

    clr1 = 1'b1;
    #1;
    checkOutput("clr_ready_low", 784'(bus1.in_ready), '0);
    step();
    clr1 = 1'b0;
    #1;
    checkOutput("clr_pixels", pix1, '0);
    checkOutput("clr_done", 784'(done1), '0);
    checkOutput("clr_frames", 784'(fr1), 784'(1));
    checkOutput("clr_ready_next", 784'(bus1.in_ready), 784'(1));
`ifdef PIXEL_LOADER_OVERRUN_EN
    checkOutput("ovr_clear", 784'(ov1), '0);
`endif

    $display("[TB] paused image on 784x1");
    send1(1, 0, 100);
    exp_part = '0;
    for (int j = 0; j < 101; j++) exp_part[683 + j] = pbit(1, j);
    for (int c = 0; c < 10; c++) begin
      st1 = 3'b000;
      bus1.in_valid = 1'b1;
      bus1.in_data = 1'b1;
      #1;
      checkOutput("pause_ready", 784'(bus1.in_ready), '0);
      step();
    end
    bus1.in_valid = 1'b0;
    checkOutput("pause_hold", pix1, exp_part);
    send1(1, 101, 783);
    checkOutput("pause_pixels", pix1, img(1));
    checkOutput("pause_done", 784'(done1), 784'(1));
    checkOutput("pause_frames", 784'(fr1), 784'(2));

    $display("[TB] clear mid-image then reload");
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    send1(1, 0, 49);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    checkOutput("mid_clr_pixels", pix1, '0);
    checkOutput("mid_clr_done", 784'(done1), '0);
    send1(0, 0, 783);
    checkOutput("reload_pixels", pix1, img(0));
    checkOutput("reload_frames", 784'(fr1), 784'(3));

    clr1 = 1'b1;
    step();
    st1 = 3'b001;
    bus1.in_valid = 1'b1;
    bus1.in_data = 1'b1;
    #1;
    checkOutput("clr_beat_ready", 784'(bus1.in_ready), '0);
    step();
    clr1 = 1'b0;
    bus1.in_valid = 1'b0;
    checkOutput("clr_beat_pixels", pix1, '0);

    $display("[TB] asynchronous reset mid-load");
    send1(0, 0, 20);
    hold = pix1;
    checkOutput("pre_rst_nonzero", 784'(hold != '0), 784'(1));
    #2;
    reset_n = 1'b0;
    st1 = 3'b000;
    st4 = 3'b000;
    #1;
    checkOutput("arst_pixels", pix1, '0);
    checkOutput("arst_done", 784'(done1), '0);
    checkOutput("arst_frames", 784'(fr1), '0);
    checkOutput("arst_frames4", 784'(fr4), '0);
    checkOutput("arst_ready", 784'(bus1.in_ready), '0);
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] frame counter saturation on 8x4");
    for (int i = 1; i <= 300; i++) begin
      clrs = 1'b1;
      step();
      clrs = 1'b0;
      sts = 3'b001;
      bus_s.in_valid = 1'b1;
      bus_s.in_data = 4'(i);
      step();
      step();
      bus_s.in_valid = 1'b0;
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        checkOutput("sat_frames", 784'(frs), 784'((i > 255) ? 255 : i));
    end
    checkOutput("sat_pixels", 784'(pixs), 784'(8'hCC));
    checkOutput("sat_done", 784'(dones), 784'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
